// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-PC selection, circular return-address stack.
// Optional performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Stall,
    input  logic                         BranchTaken,
    input  logic [WIDTH-1:0]             BranchTarget,
    input  logic                         Jump,
    input  logic [WIDTH-1:0]             JumpTarget,
    input  logic                         JumpReg,
    input  logic [WIDTH-1:0]             RegTarget,
    input  logic                         Call,
    input  logic                         Return,
    output logic [WIDTH-1:0]             PCResult,
    output logic [WIDTH-1:0]             PCAddResult,
    output logic                         Flush,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasMiss,
    output logic                         AlignErr
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]                  RedirectCount,
    output logic [31:0]                  StallCount,
    output logic [31:0]                  RasMissCount
`endif
);

    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    if ((STEP == 0) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
        $error("pc_sequencer: STEP must be a power of two");
    end
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush;
    logic             r_ras_miss;
    logic             r_align_err;

    logic [WIDTH-1:0] w_pc_add;
    logic [WIDTH-1:0] w_ras_top;
    logic [WIDTH-1:0] w_raw_target;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_next;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_active;
    logic             w_hold;
    logic             w_ras_empty;
    logic             w_jump_any;
    logic             w_ret_sel;
    logic             w_push;
    logic             w_pop;
    logic             w_ras_miss;
    logic             w_redirect;
    logic             w_misalign;

    assign w_pc_add    = r_pc + WIDTH'(STEP);
    assign w_ptr_dec   = r_ptr - PTR_W'(1);
    assign w_ras_top   = r_ras[w_ptr_dec];
    assign w_ras_empty = (r_cnt == '0);

    // Only a resolved branch overrides a stall; everything below it needs the pipe moving.
    assign w_active   = !BranchTaken && !Stall;
    assign w_hold     = Stall && !BranchTaken;
    assign w_jump_any = JumpReg || Jump;
    assign w_push     = w_active && w_jump_any && Call;
    assign w_ret_sel  = w_active && !w_jump_any && Return;
    assign w_pop      = w_ret_sel && !w_ras_empty;
    assign w_ras_miss = w_ret_sel && w_ras_empty;
    assign w_redirect = BranchTaken || (w_active && w_jump_any) || w_pop;

    always_comb begin
        w_raw_target = w_ras_top;
        if (BranchTaken) begin
            w_raw_target = BranchTarget;
        end else if (JumpReg) begin
            w_raw_target = RegTarget;
        end else if (Jump) begin
            w_raw_target = JumpTarget;
        end
    end

    // ALIGN_MASK is zero when STEP=1, which disables both masking and the error.
    assign w_target   = w_raw_target & ~ALIGN_MASK;
    assign w_misalign = w_redirect && (|(w_raw_target & ALIGN_MASK));

    always_comb begin
        w_pc_next = w_pc_add;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (w_hold) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc        <= RESET_VECTOR;
            r_flush     <= 1'b0;
            r_ras_miss  <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_flush     <= w_redirect;
            r_ras_miss  <= w_ras_miss;
            r_align_err <= w_misalign;
        end
    end

    // When full the pointer already addresses the oldest slot, so a push overwrites it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_pc_add;
        end
    end

    assign PCResult    = r_pc;
    assign PCAddResult = w_pc_add;
    assign Flush       = r_flush;
    assign RasCount    = r_cnt;
    assign RasMiss     = r_ras_miss;
    assign AlignErr    = r_align_err;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_ras_miss_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
            r_ras_miss_cnt <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ras_miss && (r_ras_miss_cnt != '1)) begin
                r_ras_miss_cnt <= r_ras_miss_cnt + 32'd1;
            end
        end
    end

    assign RedirectCount = r_redirect_cnt;
    assign StallCount    = r_stall_cnt;
    assign RasMissCount  = r_ras_miss_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus queues expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        miss;
        logic        align;
        logic [2:0]  cnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Call;
    logic        Return;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Flush;
    logic [2:0]  RasCount;
    logic        RasMiss;
    logic        AlignErr;

    exp_t q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    pc_sequencer #(
        .WIDTH        (32),
        .STEP         (4),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .JumpReg      (JumpReg),
        .RegTarget    (RegTarget),
        .Call         (Call),
        .Return       (Return),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .Flush        (Flush),
        .RasCount     (RasCount),
        .RasMiss      (RasMiss),
        .AlignErr     (AlignErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("PCResult",    PCResult,            mon_e.pc);
            check("PCAddResult", PCAddResult,         mon_e.pc + 32'd4);
            check("Flush",       {31'b0, Flush},      {31'b0, mon_e.flush});
            check("RasMiss",     {31'b0, RasMiss},    {31'b0, mon_e.miss});
            check("AlignErr",    {31'b0, AlignErr},   {31'b0, mon_e.align});
            check("RasCount",    {29'b0, RasCount},   {29'b0, mon_e.cnt});
        end
    end

    task automatic clear_inputs();
        Stall = 0; BranchTaken = 0; BranchTarget = '0;
        Jump = 0; JumpTarget = '0; JumpReg = 0; RegTarget = '0;
        Call = 0; Return = 0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic fl, input logic mi,
                            input logic al, input logic [2:0] cnt);
        exp_t e;
        e.pc = pc; e.flush = fl; e.miss = mi; e.align = al; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Clock the currently driven request, queue the state expected after the edge.
    task automatic tick(input logic [31:0] pc, input logic fl, input logic mi,
                        input logic al, input logic [2:0] cnt);
        @(posedge Clk);
        push_exp(pc, fl, mi, al, cnt);
        #1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge Clk);
        push_exp(32'h0, 0, 0, 0, 0);
        #1;
        Rst = 1'b1;

        // Sequential fetch after reset
        tick(32'h4, 0, 0, 0, 0);
        tick(32'h8, 0, 0, 0, 0);
        tick(32'hC, 0, 0, 0, 0);
        tick(32'h10, 0, 0, 0, 0);

        // Stall holds PC and swallows the jump
        for (int i = 0; i < 3; i++) begin
            Stall = 1; Jump = 1; JumpTarget = 32'h40;
            tick(32'h10, 0, 0, 0, 0);
        end
        tick(32'h14, 0, 0, 0, 0);

        // Branch overrides stall and the jump
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h100; Jump = 1; JumpTarget = 32'h40;
        tick(32'h100, 1, 0, 0, 0);
        tick(32'h104, 0, 0, 0, 0);

        // Nested calls and returns
        Jump = 1; JumpTarget = 32'h20;
        tick(32'h20, 1, 0, 0, 0);
        Call = 1; Jump = 1; JumpTarget = 32'h200;
        tick(32'h200, 1, 0, 0, 1);
        tick(32'h204, 0, 0, 0, 1);
        Call = 1; Jump = 1; JumpTarget = 32'h200;
        tick(32'h200, 1, 0, 0, 2);
        tick(32'h204, 0, 0, 0, 2);
        tick(32'h208, 0, 0, 0, 2);
        Call = 1; Jump = 1; JumpTarget = 32'h200;
        tick(32'h200, 1, 0, 0, 3);
        Return = 1; tick(32'h20C, 1, 0, 0, 2);
        Return = 1; tick(32'h208, 1, 0, 0, 1);
        Return = 1; tick(32'h24, 1, 0, 0, 0);
        Return = 1; tick(32'h28, 0, 1, 0, 0);
        tick(32'h2C, 0, 0, 0, 0);

        // Five calls into a 4-deep stack: oldest (0x30) is lost
        Call = 1; Jump = 1; JumpTarget = 32'h400; tick(32'h400, 1, 0, 0, 1);
        Call = 1; Jump = 1; JumpTarget = 32'h500; tick(32'h500, 1, 0, 0, 2);
        Call = 1; Jump = 1; JumpTarget = 32'h600; tick(32'h600, 1, 0, 0, 3);
        Call = 1; Jump = 1; JumpTarget = 32'h700; tick(32'h700, 1, 0, 0, 4);
        Call = 1; JumpReg = 1; RegTarget = 32'h800; tick(32'h800, 1, 0, 0, 4);
        Return = 1; tick(32'h704, 1, 0, 0, 3);
        Return = 1; tick(32'h604, 1, 0, 0, 2);
        Return = 1; tick(32'h504, 1, 0, 0, 1);
        Return = 1; tick(32'h404, 1, 0, 0, 0);
        Return = 1; tick(32'h408, 0, 1, 0, 0);

        // Push and pop together: only the push happens
        Call = 1; Jump = 1; JumpTarget = 32'h900; Return = 1;
        tick(32'h900, 1, 0, 0, 1);
        Return = 1; tick(32'h40C, 1, 0, 0, 0);

        // Misaligned targets are truncated and flagged
        JumpReg = 1; RegTarget = 32'h1003;
        tick(32'h1000, 1, 0, 1, 0);
        tick(32'h1004, 0, 0, 0, 0);
        BranchTaken = 1; BranchTarget = 32'h106;
        tick(32'h104, 1, 0, 1, 0);
        tick(32'h108, 0, 0, 0, 0);

        // Wrap-around at the top of the address space
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        tick(32'hFFFF_FFFC, 1, 0, 0, 0);
        tick(32'h0, 0, 0, 0, 0);
        tick(32'h4, 0, 0, 0, 0);

        // JumpReg beats Jump
        JumpReg = 1; RegTarget = 32'h70; Jump = 1; JumpTarget = 32'h90;
        tick(32'h70, 1, 0, 0, 0);
        Call = 1; Jump = 1; JumpTarget = 32'h60;
        tick(32'h60, 1, 0, 0, 1);

        // Reset with a request pending discards it and empties the stack
        @(negedge Clk);
        #1;
        Rst = 1'b0; Jump = 1; JumpTarget = 32'h50; Return = 1;
        tick(32'h0, 0, 0, 0, 0);
        Rst = 1'b1;
        tick(32'h4, 0, 0, 0, 0);
        Return = 1; tick(32'h8, 0, 1, 0, 0);
        tick(32'hC, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge Clk);
            #1;
        end
        n_assert++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; successor to the fixed PC+4 incrementer.
- Holds the PC register and selects the next PC: sequential, branch, jump, jump-register or return.
- Includes a small circular return-address stack (RAS), stall hold, a redirect flush pulse and target-alignment checking.
- Sits at the head of the IF stage. PCResult drives instruction memory. Redirect requests come from ID/EX.

Parameters:
- WIDTH, 32, PC width in bits.
- STEP, 4, sequential increment in bytes; power of two, at least 1.
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address stack entries; power of two, at least 2.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Stall  input  1  hold PC; ignored when BranchTaken=1.
- BranchTaken  input  1  EX-stage branch resolved taken.
- BranchTarget  input  WIDTH  branch destination.
- Jump  input  1  ID-stage direct jump.
- JumpTarget  input  WIDTH  jump destination.
- JumpReg  input  1  ID-stage register jump (jr).
- RegTarget  input  WIDTH  register jump destination.
- Call  input  1  push PCAddResult onto the RAS; qualifies Jump or JumpReg (jal/jalr).
- Return  input  1  pop the RAS and redirect to the popped entry.
- PCResult  output  WIDTH  current PC (registered).
- PCAddResult  output  WIDTH  PCResult+STEP, combinational, modulo 2^WIDTH.
- Flush  output  1  registered pulse for one cycle after any redirect.
- RasCount  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- RasMiss  output  1  registered pulse: Return seen with an empty RAS.
- AlignErr  output  1  registered pulse: selected target was misaligned.

Behaviour:
- Reset (Rst=0, asynchronous) sets:
  - PCResult=RESET_VECTOR.
  - Flush, RasMiss, AlignErr, RasCount = 0.
  - RAS pointer = 0; RAS contents don't-care.
- Reset asserted mid-stall or mid-redirect discards the pending request. The first fetch after release is RESET_VECTOR.
- Next-PC priority, evaluated each cycle:
  1. BranchTaken: BranchTarget.
  2. Stall=1: hold PCResult. Jump, JumpReg, Call and Return are ignored; there is no RAS change.
  3. JumpReg: RegTarget.
  4. Jump: JumpTarget.
  5. Return with RasCount>0: RAS top.
  6. Otherwise: PCAddResult.
- Redirect definition: cases 1, 3, 4 or 5. On a redirect, Flush=1 in the following cycle only. Back-to-back redirects give consecutive Flush cycles.
- Lower-priority redirect inputs asserted together with a higher one are discarded. Call still pushes if it accompanies the winning Jump or JumpReg.
- Alignment: the low log2(STEP) bits of the selected redirect target are forced to 0 and AlignErr pulses for one cycle. When STEP=1 there is no check.
- Wrap-around: PCAddResult is computed modulo 2^WIDTH, so all-ones minus STEP-1 wraps to 0 with no error.
- RAS, circular:
  - Push writes PCAddResult at the pointer, advances the pointer and increments RasCount.
  - When full, a push overwrites the oldest entry and RasCount stays at RAS_DEPTH.
  - Pop reads the entry at pointer-1, retreats the pointer and decrements RasCount.
  - Return with RasCount=0: no pop, PC goes sequential, RasMiss pulses, no Flush.
  - Push and pop in the same cycle (Call and Return while Jump or JumpReg wins): the pop is dropped and only the push occurs.
- RAS operations occur only when Stall=0 and BranchTaken=0.
- Latency: one cycle from a request to the new PCResult.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined, add outputs RedirectCount, StallCount and RasMissCount, each 32 bits.
  - RedirectCount increments on each redirect cycle.
  - StallCount increments on each cycle the PC is held.
  - RasMissCount increments on each RasMiss.
  - All three saturate at all-ones and reset to 0.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then release, with default parameters and no requests -> PCResult 0x0, 0x4, 0x8, 0xC on successive cycles; Flush=0 throughout.
- Stall=1 for 3 cycles at PC 0x10, with Jump to 0x40 asserted during the stall -> PC holds 0x10 and the jump is ignored. After release PC goes to 0x14.
- Stall=1 with BranchTaken and BranchTarget=0x100 -> next PC 0x100, Flush=1 for one cycle. Same cycle with Jump=1 -> Jump discarded.
- Call with Jump to 0x200 issued at PC 0x20, 0x204 and 0x208, then three Returns -> return targets 0x20C, 0x208, 0x24. A fourth Return -> RasMiss=1 and PC goes sequential.
- Five Calls with RAS_DEPTH=4 -> RasCount saturates at 4; the oldest entry is lost and four Returns retrieve the newest four addresses.
- JumpReg with RegTarget=0x1003 -> PC 0x1000, AlignErr=1 and Flush=1 for one cycle. PC 0xFFFFFFFC sequential -> next PC 0x0.
